mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the multicycle CPU's single unified instruction/data memory. It shares the one memory port between the CPU (fetch/load/store traffic steered by the `iord` path) and a loader/debug port. Each access is issued as a one-cycle registered memory strobe, waited out for a fixed read latency, and completed with a one-cycle acknowledge. Simultaneous requests are served round-robin.

## Interface
- AW, 16, address width
- DW, 16, data width
- LAT, 2, memory read latency in cycles; legal range 1..15
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- cpu_req  input  1  CPU access request; held high until `cpu_ack`
- cpu_we  input  1  1 = store, 0 = load/fetch
- cpu_addr  input  AW  CPU address
- cpu_wdata  input  DW  CPU store data
- cpu_rdata  output  DW  CPU read data register
- cpu_ack  output  1  one-cycle completion pulse to CPU
- ldr_req, ldr_we, ldr_addr, ldr_wdata  input  1/1/AW/DW  loader request fields, same rules as CPU
- ldr_rdata  output  DW  loader read data register
- ldr_ack  output  1  one-cycle completion pulse to loader
- mem_en  output  1  memory strobe, registered
- mem_we  output  1  memory write enable, registered
- mem_addr  output  AW  memory address, registered
- mem_wdata  output  DW  memory write data, registered
- mem_rdata  input  DW  memory read data; valid exactly LAT cycles after the `mem_en` cycle
- gnt_ldr  output  1  owner of the current or last transaction (0 = CPU, 1 = loader)
- busy  output  1  high in every state except IDLE

## Operation
- State encoding: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one requester has req = 1, grant it.
  - If both do, grant the one that was not `gnt_ldr` last time (round-robin).
  - On grant: latch we/addr/wdata into the mem_* registers, set `gnt_ldr`, and go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - mem_en = 1 for exactly this cycle; mem_we = latched we.
  - Write: go to ACK.
  - Read: load the counter with LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter equals 1, capture mem_rdata into the granted requester's rdata register, then go to ACK.
  - WAIT therefore lasts exactly LAT cycles.
- ACK: pulse the granted requester's ack for one cycle, then go to IDLE.
- Requester rule: req must be low in the cycle after its ack unless a new access is wanted.
- Because IDLE follows every ACK, a requester never gets back-to-back grants without one idle cycle in between.
- mem_en and mem_we are 0 in IDLE, WAIT and ACK.
- mem_addr and mem_wdata hold their last values.
- The rdata register of the non-granted requester is never modified.
- A write never modifies either rdata register.
- Deasserting req after grant is a protocol violation. The arbiter ignores it: the transaction completes and ack still pulses.
- Req/we/addr/wdata changes after grant have no effect; the fields are latched in IDLE.

## Timing
- Reset values:
  - state = IDLE
  - cpu_ack = ldr_ack = 0
  - cpu_rdata = ldr_rdata = 0
  - mem_en = mem_we = 0
  - mem_addr = mem_wdata = 0
  - gnt_ldr = 1, so the CPU wins the first tie
  - busy = 0
  - counter = 0
- Reset asserted mid-transaction: the next edge returns to IDLE, mem_en = 0, and no ack is issued. Any pending rdata capture is lost.
- Request seen in IDLE at cycle t:
  - ISSUE at t+1.
  - Write: ack at t+2.
  - Read: WAIT from t+2 to t+1+LAT, capture at the end of t+1+LAT, ack at t+2+LAT. The new rdata is visible in the ack cycle.
- Throughput: one write per 3 cycles, one read per LAT+3 cycles.
- Both requesters held high continuously: grants alternate CPU, loader, CPU, …
- ack is a registered output from the ACK state, never combinational from req.
- Counter width is 4 bits. LAT = 1 gives a single WAIT cycle.

## Test plan
- **Reset/idle.** Reset 3 cycles with no requests. Required: every output at its reset value, busy = 0, mem_en never high.
- **CPU read, LAT=2.** cpu_req at t with addr 0x0010; memory model returns 0xBEEF two cycles after the strobe. Required:
  - mem_en = 1 with mem_addr = 0x0010 only at t+1
  - cpu_ack only at t+4, with cpu_rdata = 0xBEEF
  - ldr_rdata unchanged
- **Loader write.** ldr_we = 1, addr 0x0003, data 0x1234 at t. Required: at t+1, mem_en = mem_we = 1, mem_addr = 0x0003, mem_wdata = 0x1234; ldr_ack at t+2; both rdata registers unchanged.
- **Tie and round-robin.** Both req held high after reset, reads. Required:
  - grant order CPU, loader, CPU
  - gnt_ldr = 0, 1, 0
  - each ack single-cycle
  - consecutive ISSUE cycles exactly LAT+3 apart
- **Reset mid-WAIT.** Reset asserted during the first WAIT cycle of a CPU read. Required: IDLE on the next edge, no cpu_ack at any point, cpu_rdata = 0.
- **LAT=1 sweep plus req dropped after grant.** Run with LAT = 1. Required: read ack at t+3. Then deassert cpu_req in ISSUE; the transaction still completes with cpu_ack at t+3.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter_if : requester and memory-side signals of mem_port_arbiter |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic [DW-1:0] ldr_rdata;
  logic          ldr_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          gnt_ldr;
  logic          busy;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output gnt_ldr, busy
  );

  // Requesters plus memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  gnt_ldr, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter : round-robin CPU/loader sequencer for one shared mem port |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  wire               clk,
  input  wire               reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] c_LAT = 4'(LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_gnt_ldr;
  logic          r_busy;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;
  logic          r_cpu_ack;
  logic          r_ldr_ack;

  logic          w_any_req;
  logic          w_pick_ldr;

  // On a tie the loader wins only if the CPU owned the previous transaction.
  assign w_any_req  = bus.cpu_req | bus.ldr_req;
  assign w_pick_ldr = bus.ldr_req & (~bus.cpu_req | ~r_gnt_ldr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_gnt_ldr   <= 1'b1;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
    end else begin
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_ldr_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_ISSUE;
            r_busy    <= 1'b1;
            r_gnt_ldr <= w_pick_ldr;
            r_mem_en  <= 1'b1;
            if (w_pick_ldr) begin
              r_mem_we    <= bus.ldr_we;
              r_mem_addr  <= bus.ldr_addr;
              r_mem_wdata <= bus.ldr_wdata;
            end else begin
              r_mem_we    <= bus.cpu_we;
              r_mem_addr  <= bus.cpu_addr;
              r_mem_wdata <= bus.cpu_wdata;
            end
          end
        end
        // r_mem_we still holds the latched direction during the strobe cycle.
        S_ISSUE: begin
          if (r_mem_we) begin
            r_state   <= S_ACK;
            r_cpu_ack <= ~r_gnt_ldr;
            r_ldr_ack <= r_gnt_ldr;
          end else begin
            r_cnt   <= c_LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_gnt_ldr) begin
              r_ldr_rdata <= bus.mem_rdata;
            end else begin
              r_cpu_rdata <= bus.mem_rdata;
            end
            r_state   <= S_ACK;
            r_cpu_ack <= ~r_gnt_ldr;
            r_ldr_ack <= r_gnt_ldr;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.ldr_rdata = r_ldr_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.ldr_ack   = r_ldr_ack;
  assign bus.gnt_ldr   = r_gnt_ldr;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter : scoreboard bench, one LAT=2 and one LAT=1 arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_total = 0;
  int   n_bad   = 0;

  typedef struct {
    logic        ldr;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } txn_t;

  txn_t iq2[$];
  txn_t sb2[$];
  txn_t iq1[$];
  txn_t sb1[$];
  logic [15:0] e_cpu2 = 16'h0, e_ldr2 = 16'h0, e_cpu1 = 16'h0, e_ldr1 = 16'h0;

  mem_port_arbiter_if #(.AW(16), .DW(16)) b2 ();
  mem_port_arbiter_if #(.AW(16), .DW(16)) b1 ();

  mem_port_arbiter #(.AW(16), .DW(16), .LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));
  mem_port_arbiter #(.AW(16), .DW(16), .LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : ((a ^ 16'hA5A5) + 16'h0101);
  endfunction

  // Memory models: read data is valid only in the cycle LAT after the strobe.
  int left2 = 0, left1 = 0;
  logic [15:0] val2 = 16'h0, val1 = 16'h0;
  always @(posedge clk) begin
    if (reset) left2 <= 0;
    else if (b2.mem_en === 1'b1 && b2.mem_we === 1'b0) begin left2 <= 2; val2 <= mem_val(b2.mem_addr); end
    else if (left2 > 0) left2 <= left2 - 1;
    if (reset) left1 <= 0;
    else if (b1.mem_en === 1'b1 && b1.mem_we === 1'b0) begin left1 <= 1; val1 <= mem_val(b1.mem_addr); end
    else if (left1 > 0) left1 <= left1 - 1;
  end
  assign b2.mem_rdata = (left2 == 1) ? val2 : 16'hDEAD;
  assign b1.mem_rdata = (left1 == 1) ? val1 : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input logic ldr, input logic we, input logic [15:0] a,
                              input logic [15:0] d, input int c);
    txn_t t;
    t.ldr = ldr; t.we = we; t.addr = a; t.data = d; t.cyc = c;
    return t;
  endfunction

  always @(negedge clk) begin : mon2
    txn_t t;
    if (reset) begin e_cpu2 = 16'h0; e_ldr2 = 16'h0; end
    else if (b2.mem_en !== 1'b1) chk("we_without_en_l2", 32'(b2.mem_we), 0);
    if (b2.mem_en === 1'b1) begin
      if (iq2.size() == 0) chk("strobe_unexpected_l2", 32'(b2.mem_en), 0);
      else begin
        t = iq2.pop_front();
        chk("strobe_cycle_l2", cyc, t.cyc);
        chk("strobe_we_l2", 32'(b2.mem_we), 32'(t.we));
        chk("strobe_addr_l2", 32'(b2.mem_addr), 32'(t.addr));
        if (t.we) chk("strobe_wdata_l2", 32'(b2.mem_wdata), 32'(t.data));
        chk("strobe_gnt_l2", 32'(b2.gnt_ldr), 32'(t.ldr));
        chk("strobe_busy_l2", 32'(b2.busy), 1);
      end
    end
    if (b2.cpu_ack === 1'b1 || b2.ldr_ack === 1'b1) begin
      if (sb2.size() == 0) chk("ack_unexpected_l2", 32'({b2.ldr_ack, b2.cpu_ack}), 0);
      else begin
        t = sb2.pop_front();
        chk("ack_cycle_l2", cyc, t.cyc);
        chk("ack_owner_l2", 32'({b2.ldr_ack, b2.cpu_ack}), t.ldr ? 2 : 1);
        if (!t.we) begin if (t.ldr) e_ldr2 = t.data; else e_cpu2 = t.data; end
        chk("cpu_rdata_l2", 32'(b2.cpu_rdata), 32'(e_cpu2));
        chk("ldr_rdata_l2", 32'(b2.ldr_rdata), 32'(e_ldr2));
      end
    end
  end

  always @(negedge clk) begin : mon1
    txn_t t;
    if (reset) begin e_cpu1 = 16'h0; e_ldr1 = 16'h0; end
    else if (b1.mem_en !== 1'b1) chk("we_without_en_l1", 32'(b1.mem_we), 0);
    if (b1.mem_en === 1'b1) begin
      if (iq1.size() == 0) chk("strobe_unexpected_l1", 32'(b1.mem_en), 0);
      else begin
        t = iq1.pop_front();
        chk("strobe_cycle_l1", cyc, t.cyc);
        chk("strobe_we_l1", 32'(b1.mem_we), 32'(t.we));
        chk("strobe_addr_l1", 32'(b1.mem_addr), 32'(t.addr));
        if (t.we) chk("strobe_wdata_l1", 32'(b1.mem_wdata), 32'(t.data));
        chk("strobe_gnt_l1", 32'(b1.gnt_ldr), 32'(t.ldr));
      end
    end
    if (b1.cpu_ack === 1'b1 || b1.ldr_ack === 1'b1) begin
      if (sb1.size() == 0) chk("ack_unexpected_l1", 32'({b1.ldr_ack, b1.cpu_ack}), 0);
      else begin
        t = sb1.pop_front();
        chk("ack_cycle_l1", cyc, t.cyc);
        chk("ack_owner_l1", 32'({b1.ldr_ack, b1.cpu_ack}), t.ldr ? 2 : 1);
        if (!t.we) begin if (t.ldr) e_ldr1 = t.data; else e_cpu1 = t.data; end
        chk("cpu_rdata_l1", 32'(b1.cpu_rdata), 32'(e_cpu1));
        chk("ldr_rdata_l1", 32'(b1.ldr_rdata), 32'(e_ldr1));
      end
    end
  end

  task automatic drive(input int lane, input logic ldr, input logic req, input logic we,
                       input logic [15:0] a, input logic [15:0] d);
    if (lane == 2) begin
      if (ldr) begin b2.ldr_req = req; b2.ldr_we = we; b2.ldr_addr = a; b2.ldr_wdata = d; end
      else     begin b2.cpu_req = req; b2.cpu_we = we; b2.cpu_addr = a; b2.cpu_wdata = d; end
    end else begin
      if (ldr) begin b1.ldr_req = req; b1.ldr_we = we; b1.ldr_addr = a; b1.ldr_wdata = d; end
      else     begin b1.cpu_req = req; b1.cpu_we = we; b1.cpu_addr = a; b1.cpu_wdata = d; end
    end
  endtask

  function automatic logic ack_seen(input int lane, input logic ldr);
    if (lane == 2) return ldr ? b2.ldr_ack : b2.cpu_ack;
    return ldr ? b1.ldr_ack : b1.cpu_ack;
  endfunction

  // One access from an idle arbiter; optionally drops and scrambles the request after grant.
  task automatic xact(input int lane, input logic ldr, input logic we, input logic [15:0] a,
                      input logic [15:0] d, input bit drop);
    int t0;
    int lat;
    bit seen;
    t0   = cyc;
    lat  = (lane == 2) ? 2 : 1;
    seen = 1'b0;
    drive(lane, ldr, 1'b1, we, a, d);
    if (lane == 2) begin
      iq2.push_back(mk(ldr, we, a, d, t0 + 1));
      sb2.push_back(mk(ldr, we, a, we ? 16'h0 : mem_val(a), t0 + 2 + (we ? 0 : lat)));
    end else begin
      iq1.push_back(mk(ldr, we, a, d, t0 + 1));
      sb1.push_back(mk(ldr, we, a, we ? 16'h0 : mem_val(a), t0 + 2 + (we ? 0 : lat)));
    end
    if (drop) begin
      @(posedge clk); #1;
      drive(lane, ldr, 1'b0, ~we, ~a, ~d);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = ack_seen(lane, ldr);
    end
    chk("ack_timeout", 32'(seen), 1);
    drive(lane, ldr, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int t0;
    drive(2, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(2, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ack", 32'(b2.cpu_ack), 0);
    chk("rst_ldr_ack", 32'(b2.ldr_ack), 0);
    chk("rst_cpu_rdata", 32'(b2.cpu_rdata), 0);
    chk("rst_ldr_rdata", 32'(b2.ldr_rdata), 0);
    chk("rst_mem_en", 32'(b2.mem_en), 0);
    chk("rst_mem_we", 32'(b2.mem_we), 0);
    chk("rst_mem_addr", 32'(b2.mem_addr), 0);
    chk("rst_mem_wdata", 32'(b2.mem_wdata), 0);
    chk("rst_gnt_ldr", 32'(b2.gnt_ldr), 1);
    chk("rst_busy", 32'(b2.busy), 0);
    chk("rst_gnt_ldr_l1", 32'(b1.gnt_ldr), 1);
    chk("rst_busy_l1", 32'(b1.busy), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 32'(b2.busy), 0);

    xact(2, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
    xact(2, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    chk("cpu_read_beef", 32'(b2.cpu_rdata), 32'h0000BEEF);
    xact(2, 1'b1, 1'b1, 16'h0003, 16'h1234, 1'b0);
    xact(2, 1'b0, 1'b1, 16'h0005, 16'h5A5A, 1'b0);

    // CPU read aborted by reset in its first WAIT cycle.
    t0 = cyc;
    drive(2, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
    iq2.push_back(mk(1'b0, 1'b0, 16'h0040, 16'h0, t0 + 1));
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("wait_busy", 32'(b2.busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", 32'(b2.busy), 0);
    chk("midrst_mem_en", 32'(b2.mem_en), 0);
    chk("midrst_cpu_rdata", 32'(b2.cpu_rdata), 0);
    chk("midrst_gnt_ldr", 32'(b2.gnt_ldr), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_cpu_rdata_late", 32'(b2.cpu_rdata), 0);
    chk("midrst_idle", 32'(b2.busy), 0);

    // Both requesters held: CPU, loader, CPU with issues LAT+3 apart.
    t0 = cyc;
    b2.cpu_we = 1'b0; b2.cpu_addr = 16'h0020;
    b2.ldr_we = 1'b0; b2.ldr_addr = 16'h0030;
    b2.cpu_req = 1'b1; b2.ldr_req = 1'b1;
    iq2.push_back(mk(1'b0, 1'b0, 16'h0020, 16'h0, t0 + 1));
    iq2.push_back(mk(1'b1, 1'b0, 16'h0030, 16'h0, t0 + 6));
    iq2.push_back(mk(1'b0, 1'b0, 16'h0021, 16'h0, t0 + 11));
    sb2.push_back(mk(1'b0, 1'b0, 16'h0020, mem_val(16'h0020), t0 + 4));
    sb2.push_back(mk(1'b1, 1'b0, 16'h0030, mem_val(16'h0030), t0 + 9));
    sb2.push_back(mk(1'b0, 1'b0, 16'h0021, mem_val(16'h0021), t0 + 14));
    @(posedge clk); #1;
    b2.cpu_addr = 16'h0021;
    repeat (8) @(posedge clk);
    #1;
    b2.ldr_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    b2.cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    xact(1, 1'b0, 1'b0, 16'h0050, 16'h0000, 1'b0);
    xact(1, 1'b0, 1'b0, 16'h0051, 16'h0000, 1'b1);
    xact(1, 1'b1, 1'b0, 16'h0052, 16'h0000, 1'b0);
    xact(1, 1'b1, 1'b1, 16'h0007, 16'hCAFE, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    chk("pending_strobes_l2", iq2.size(), 0);
    chk("pending_acks_l2", sb2.size(), 0);
    chk("pending_strobes_l1", iq1.size(), 0);
    chk("pending_acks_l1", sb1.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish by time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
